// File: rtl/ceespu_pkg.sv
// Shared definitions for the ceespu front end: default widths, NOP encoding
// and the fetch-entry record carried between the fetch registers.
package ceespu_pkg;

    localparam int unsigned CEESPU_ADDR_W = 14;
    localparam int unsigned CEESPU_DATA_W = 32;
    localparam logic [31:0] CEESPU_NOP    = 32'h0000_0000;

    typedef struct packed {
        logic                     valid;
        logic [CEESPU_ADDR_W-1:0] pc;
        logic [CEESPU_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ceespu_fetch_skid.sv
// One-entry skid register for the fetch stage. Load wins over drain; flush
// (branch or reset) clears the entry regardless of the other controls.
module ceespu_fetch_skid
    import ceespu_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk_i,
    input  logic   flush_i,
    input  logic   load_i,
    input  logic   drain_i,
    input  entry_t entry_i,
    output entry_t entry_o
);

    entry_t skid_d, skid_q;

    always_comb begin
        skid_d = skid_q;
        if (flush_i) begin
            skid_d.valid = 1'b0;
        end else if (load_i) begin
            skid_d = entry_i;
        end else if (drain_i) begin
            skid_d.valid = 1'b0;
        end
    end

    // Payload needs no reset: valid is cleared by flush, which reset drives.
    always_ff @(posedge clk_i) begin
        skid_q <= skid_d;
    end

    assign entry_o = skid_q;

endmodule

// File: rtl/ceespu_fetch.sv
// Instruction-fetch stage: issues 1-cycle-latency imem reads and registers the
// returned word with its PC. Optional counters under CEESPU_FETCH_PERF_EN.
module ceespu_fetch
    import ceespu_pkg::*;
#(
    parameter int unsigned       ADDR_W = CEESPU_ADDR_W,
    parameter int unsigned       DATA_W = CEESPU_DATA_W,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(CEESPU_NOP)
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic [ADDR_W-1:0] I_PC,
    input  logic              I_stall,
    input  logic              I_branch,
    output logic [ADDR_W-1:0] O_imemAddress,
    output logic              O_imemEnable,
    input  logic [DATA_W-1:0] I_imemData,
    output logic [DATA_W-1:0] O_instruction,
    output logic [ADDR_W-1:0] O_instrPC,
    output logic              O_valid
`ifdef CEESPU_FETCH_PERF_EN
    ,
    output logic [31:0]       O_fetchCount,
    output logic [31:0]       O_flushCount
`endif
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic              req_valid_d, req_valid_q;
    logic [ADDR_W-1:0] req_pc_d, req_pc_q;
    entry_t            out_d, out_q;
    entry_t            req_entry, skid_entry, src;
    logic              enable, flush, skid_load, skid_drain;

    assign enable        = !I_rst && !I_branch && !I_stall && !skid_entry.valid;
    assign flush         = I_rst || I_branch;
    assign O_imemAddress = I_PC;
    assign O_imemEnable  = enable;

    always_comb begin
        req_entry.valid = req_valid_q;
        req_entry.pc    = req_pc_q;
        req_entry.instr = I_imemData;
    end

    ceespu_fetch_skid #(
        .entry_t (entry_t)
    ) u_skid (
        .clk_i   (I_clk),
        .flush_i (flush),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .entry_i (req_entry),
        .entry_o (skid_entry)
    );

    always_comb begin
        req_valid_d = enable;
        req_pc_d    = enable ? I_PC : req_pc_q;
        src         = skid_entry.valid ? skid_entry : req_entry;
        out_d       = out_q;
        skid_load   = 1'b0;
        skid_drain  = 1'b0;
        if (I_branch) begin
            out_d.valid = 1'b0;
            out_d.instr = NOP;
        end else if (!I_stall) begin
            if (src.valid) begin
                out_d = src;
            end else begin
                out_d.valid = 1'b0;
                out_d.instr = NOP;
            end
            // Drain the skid; a request arriving behind it takes its place.
            skid_drain = 1'b1;
            skid_load  = skid_entry.valid && req_valid_q;
        end else begin
            skid_load = req_valid_q && !skid_entry.valid;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            out_q.valid <= 1'b0;
            out_q.pc    <= '0;
            out_q.instr <= NOP;
        end else begin
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
            out_q       <= out_d;
        end
    end

    assign O_valid       = out_q.valid;
    assign O_instrPC     = out_q.pc;
    assign O_instruction = out_q.instr;

`ifdef CEESPU_FETCH_PERF_EN
    logic [31:0] fetch_count_d, fetch_count_q;
    logic [31:0] flush_count_d, flush_count_q;
    logic        fetch_load, flush_hit;

    assign fetch_load = !I_branch && !I_stall && src.valid;
    assign flush_hit  = I_branch && (req_valid_q || skid_entry.valid || out_q.valid);

    always_comb begin
        fetch_count_d = fetch_count_q + (fetch_load ? 32'd1 : 32'd0);
        flush_count_d = flush_count_q + (flush_hit ? 32'd1 : 32'd0);
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign O_fetchCount = fetch_count_q;
    assign O_flushCount = flush_count_q;
`endif

    // The enable term keeps a request and a skid entry from ever coexisting.
    assert property (@(posedge I_clk) disable iff (I_rst) !(req_valid_q && skid_entry.valid));

endmodule

// File: tb/tb_ceespu_fetch.sv
// Directed bench for ceespu_fetch with a synchronous 1-cycle instruction memory.
module tb_ceespu_fetch;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        stall  = 1'b0;
    logic        branch = 1'b0;
    logic [13:0] pc     = '0;
    logic [13:0] addr;
    logic        en;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [13:0] ipc;
    logic        valid;
`ifdef CEESPU_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    ceespu_fetch dut (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_PC          (pc),
        .I_stall       (stall),
        .I_branch      (branch),
        .O_imemAddress (addr),
        .O_imemEnable  (en),
        .I_imemData    (mem_data),
        .O_instruction (instr),
        .O_instrPC     (ipc),
        .O_valid       (valid)
`ifdef CEESPU_FETCH_PERF_EN
        ,
        .O_fetchCount  (fetch_cnt),
        .O_flushCount  (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data <= en ? (32'hA000_0000 + {18'h0, addr}) : 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] word(input logic [13:0] a);
        return 32'hA000_0000 + {18'h0, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [13:0] p, input logic s, input logic b);
        pc = p;
        stall = s;
        branch = b;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(14'h0, 1'b0, 1'b0);
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL reset_enable got=%b want=0", en);
        end
        tick();
        tick();
        checks++;
        if (valid !== 1'b0 || instr !== 32'h0 || ipc !== 14'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b pc=%h i=%h want v=0 pc=0 i=0", valid, ipc, instr);
        end
`ifdef CEESPU_FETCH_PERF_EN
        checks++;
        if (fetch_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got f=%0d b=%0d want 0 0", fetch_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_stream();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(14'(c), 1'b0, 1'b0);
            checks++;
            if (addr !== 14'(c) || en !== 1'b1) begin
                errors++;
                $display("FAIL stream_issue c=%0d got addr=%h en=%b want addr=%h en=1",
                         c, addr, en, 14'(c));
            end
            tick();
            checks++;
            if (c == 0) begin
                if (valid !== 1'b0 || instr !== 32'h0) begin
                    errors++;
                    $display("FAIL stream_first got v=%b i=%h want v=0 i=0", valid, instr);
                end
            end else if (valid !== 1'b1 || ipc !== 14'(c - 1) || instr !== word(14'(c - 1))) begin
                errors++;
                $display("FAIL stream_out c=%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         c, valid, ipc, instr, 14'(c - 1), word(14'(c - 1)));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(14'h6, 1'b1, 1'b0);
            checks++;
            if (en !== 1'b0) begin
                errors++;
                $display("FAIL stall_enable i=%0d got=%b want=0", i, en);
            end
            tick();
            checks++;
            if (valid !== 1'b1 || ipc !== 14'h4 || instr !== 32'hA000_0004) begin
                errors++;
                $display("FAIL stall_hold i=%0d got v=%b pc=%h i=%h want v=1 pc=4 i=a0000004",
                         i, valid, ipc, instr);
            end
        end
        drive(14'h6, 1'b0, 1'b0);
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL skid_drain_enable got=%b want=0", en);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h5 || instr !== 32'hA000_0005) begin
            errors++;
            $display("FAIL skid_out got v=%b pc=%h i=%h want v=1 pc=5 i=a0000005", valid, ipc, instr);
        end
        drive(14'h6, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL stall_bubble got v=%b i=%h want v=0 i=0", valid, instr);
        end
        drive(14'h7, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h6 || instr !== 32'hA000_0006) begin
            errors++;
            $display("FAIL after_stall6 got v=%b pc=%h i=%h want v=1 pc=6 i=a0000006", valid, ipc, instr);
        end
        drive(14'h8, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h7 || instr !== 32'hA000_0007) begin
            errors++;
            $display("FAIL after_stall7 got v=%b pc=%h i=%h want v=1 pc=7 i=a0000007", valid, ipc, instr);
        end
    endtask

    task automatic test_branch();
        rst = 1'b1;
        drive(14'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(14'h8, 1'b0, 1'b0);
        tick();
        drive(14'h9, 1'b0, 1'b0);
        tick();
        drive(14'hA, 1'b1, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h8) begin
            errors++;
            $display("FAIL branch_setup got v=%b pc=%h want v=1 pc=8", valid, ipc);
        end
        drive(14'hA, 1'b0, 1'b1);
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL branch_enable got=%b want=0", en);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL branch_flush1 got v=%b i=%h want v=0 i=0", valid, instr);
        end
        drive(14'h100, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL branch_flush2 got v=%b pc=%h i=%h want v=0 i=0", valid, ipc, instr);
        end
        drive(14'h101, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h100 || instr !== 32'hA000_0100) begin
            errors++;
            $display("FAIL branch_target got v=%b pc=%h i=%h want v=1 pc=100 i=a0000100",
                     valid, ipc, instr);
        end
        drive(14'h102, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h101 || instr !== 32'hA000_0101) begin
            errors++;
            $display("FAIL branch_next got v=%b pc=%h i=%h want v=1 pc=101 i=a0000101",
                     valid, ipc, instr);
        end
    endtask

    task automatic test_branch_stall();
        drive(14'h102, 1'b1, 1'b1);
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL brstall_enable got=%b want=0", en);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL brstall_flush got v=%b i=%h want v=0 i=0", valid, instr);
        end
        drive(14'h300, 1'b0, 1'b0);
        tick();
        drive(14'h301, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h300 || instr !== 32'hA000_0300) begin
            errors++;
            $display("FAIL brstall_target got v=%b pc=%h i=%h want v=1 pc=300 i=a0000300",
                     valid, ipc, instr);
        end
    endtask

    task automatic test_reset_mid();
        drive(14'h20, 1'b0, 1'b0);
        tick();
        drive(14'h21, 1'b0, 1'b0);
        tick();
        drive(14'h22, 1'b1, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h20) begin
            errors++;
            $display("FAIL rstmid_setup got v=%b pc=%h want v=1 pc=20", valid, ipc);
        end
        rst = 1'b1;
        drive(14'h22, 1'b1, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b0 || instr !== 32'h0 || ipc !== 14'h0) begin
            errors++;
            $display("FAIL rstmid_state got v=%b pc=%h i=%h want v=0 pc=0 i=0", valid, ipc, instr);
        end
`ifdef CEESPU_FETCH_PERF_EN
        checks++;
        if (fetch_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_counters got f=%0d b=%0d want 0 0", fetch_cnt, flush_cnt);
        end
`endif
        rst = 1'b0;
        drive(14'h40, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_skid_gone got v=%b pc=%h i=%h want v=0 i=0", valid, ipc, instr);
        end
        drive(14'h41, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h40 || instr !== 32'hA000_0040) begin
            errors++;
            $display("FAIL rstmid_resume got v=%b pc=%h i=%h want v=1 pc=40", valid, ipc, instr);
        end
    endtask

    task automatic test_wrap();
        drive(14'h3FFE, 1'b0, 1'b0);
        tick();
        drive(14'h3FFF, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h3FFE || instr !== 32'hA000_3FFE) begin
            errors++;
            $display("FAIL wrap_3ffe got v=%b pc=%h i=%h want v=1 pc=3ffe", valid, ipc, instr);
        end
        drive(14'h0000, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h3FFF || instr !== 32'hA000_3FFF) begin
            errors++;
            $display("FAIL wrap_3fff got v=%b pc=%h i=%h want v=1 pc=3fff", valid, ipc, instr);
        end
        drive(14'h0001, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'h0000 || instr !== 32'hA000_0000) begin
            errors++;
            $display("FAIL wrap_0000 got v=%b pc=%h i=%h want v=1 pc=0000", valid, ipc, instr);
        end
    endtask

    task automatic test_perf();
        rst = 1'b1;
        drive(14'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            drive(14'(c), 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (valid !== 1'b1 || ipc !== 14'd98) begin
            errors++;
            $display("FAIL perf_stream got v=%b pc=%h want v=1 pc=62", valid, ipc);
        end
        drive(14'd100, 1'b1, 1'b0);
        tick();
        drive(14'd100, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 14'd99 || instr !== 32'hA000_0063) begin
            errors++;
            $display("FAIL perf_last got v=%b pc=%h i=%h want v=1 pc=63", valid, ipc, instr);
        end
        drive(14'd100, 1'b0, 1'b1);
        tick();
        drive(14'h200, 1'b0, 1'b0);
        tick();
        drive(14'h200, 1'b0, 1'b1);
        tick();
        drive(14'h201, 1'b0, 1'b0);
        tick();
        drive(14'h201, 1'b0, 1'b1);
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL perf_flushed got v=%b want v=0", valid);
        end
        drive(14'h0, 1'b1, 1'b0);
        tick();
`ifdef CEESPU_FETCH_PERF_EN
        checks++;
        if (fetch_cnt !== 32'd100 || flush_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_counts got f=%0d b=%0d want f=100 b=3", fetch_cnt, flush_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_branch_stall();
        test_reset_mid();
        test_wrap();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
